// File: rtl/banked_reg_file_pkg.sv
// reg_file_pkg: shared types and default widths for the banked register file
package reg_file_pkg;
  localparam int DW_DEF = 8;
  localparam int AW_DEF = 3;
  typedef enum logic [1:0] {CTX_NOP = 2'd0, CTX_SAVE = 2'd1, CTX_RESTORE = 2'd2, CTX_RSVD = 2'd3} ctx_cmd_e;
  typedef enum logic [1:0] {IDLE = 2'd0, SAVE = 2'd1, RESTORE = 2'd2} ctx_state_e;
endpackage

// File: rtl/banked_reg_file_if.sv
// banked_reg_file_if: decode/writeback and context-command bus of the register file
interface banked_reg_file_if
  import reg_file_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int RS_AW = 2
);
  logic [RS_AW-1:0] rs;
  logic [AW-1:0] rt;
  logic [AW-1:0] wr_addr;
  logic write_enable;
  logic [DW-1:0] write_data;
  logic cout_write_enable;
  logic [DW-1:0] cout_data;
  logic [DW-1:0] rs_val_o;
  logic [DW-1:0] rt_val_o;
  logic ctx_req;
  logic [1:0] ctx_cmd;
  logic wr_ready;
  logic ctx_busy;
  logic ctx_done;
  logic ctx_err;
  logic shadow_valid;
  modport master (
    output rs, rt, wr_addr, write_enable, write_data, cout_write_enable, cout_data, ctx_req, ctx_cmd,
    input rs_val_o, rt_val_o, wr_ready, ctx_busy, ctx_done, ctx_err, shadow_valid
  );
  modport slave (
    input rs, rt, wr_addr, write_enable, write_data, cout_write_enable, cout_data, ctx_req, ctx_cmd,
    output rs_val_o, rt_val_o, wr_ready, ctx_busy, ctx_done, ctx_err, shadow_valid
  );
endinterface

// File: rtl/banked_reg_file_ctx_seq.sv
// reg_ctx_seq: context save/restore sequencer walking every register once per command
module reg_ctx_seq
  import reg_file_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic ctx_req,
  input  logic [1:0] ctx_cmd,
  output logic ctx_busy,
  output logic ctx_done,
  output logic ctx_err,
  output logic shadow_valid,
  output logic copy_en,
  output logic copy_dir,
  output logic [AW-1:0] copy_idx
);
  ctx_state_e r_state, w_next;
  ctx_cmd_e w_cmd;
  logic [AW-1:0] r_idx;
  logic r_done, r_err, r_sv, w_err, w_last;
  assign w_cmd = ctx_cmd_e'(ctx_cmd);
  assign w_last = &r_idx;
  always_comb begin
    w_next = r_state;
    w_err = 1'b0;
    case (r_state)
      IDLE:
        if (ctx_req) begin
          if (w_cmd == CTX_SAVE) w_next = SAVE;
          else if (w_cmd == CTX_RESTORE && r_sv) w_next = RESTORE;
          else w_err = w_cmd != CTX_NOP;
        end
      default: w_next = w_last ? IDLE : r_state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      r_sv <= 1'b0;
    end else begin
      r_state <= w_next;
      r_idx <= (r_state != IDLE) ? r_idx + 1'b1 : '0;
      r_done <= (r_state != IDLE) && w_last;
      r_err <= w_err;
      if (r_state == SAVE && w_last) r_sv <= 1'b1;
    end
  end
  assign ctx_busy = r_state != IDLE;
  assign ctx_done = r_done;
  assign ctx_err = r_err;
  assign shadow_valid = r_sv;
  assign copy_en = r_state != IDLE;
  assign copy_dir = r_state == RESTORE;
  assign copy_idx = r_idx;
endmodule

// File: rtl/banked_reg_file.sv
// banked_reg_file: register file with COUT port, write forwarding and a shadow bank for context switches
module banked_reg_file
  import reg_file_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int RS_AW = 2,
  parameter int COUT_IDX = 2**AW - 1,
  parameter bit BYPASS = 1'b1
) (
  input logic clk,
  input logic reset,
  banked_reg_file_if.slave bus
);
  localparam int DEPTH = 2**AW;
  localparam logic [AW-1:0] W_COUT = AW'(COUT_IDX);
  logic [DW-1:0] r_rf [DEPTH];
  logic [DW-1:0] r_shadow [DEPTH];
  logic w_busy, w_we, w_cwe, w_copy_en, w_copy_dir;
  logic [AW-1:0] w_copy_idx, w_rs;
  reg_ctx_seq #(.AW(AW)) u_seq (
    .clk(clk),
    .reset(reset),
    .ctx_req(bus.ctx_req),
    .ctx_cmd(bus.ctx_cmd),
    .ctx_busy(w_busy),
    .ctx_done(bus.ctx_done),
    .ctx_err(bus.ctx_err),
    .shadow_valid(bus.shadow_valid),
    .copy_en(w_copy_en),
    .copy_dir(w_copy_dir),
    .copy_idx(w_copy_idx)
  );
  assign bus.ctx_busy = w_busy;
  assign bus.wr_ready = !w_busy;
  assign w_we = bus.write_enable && !w_busy;
  assign w_cwe = bus.cout_write_enable && !w_busy;
  assign w_rs = AW'(bus.rs);
  assign bus.rs_val_o = (BYPASS && w_cwe && w_rs == W_COUT) ? bus.cout_data :
                        (BYPASS && w_we && w_rs == bus.wr_addr) ? bus.write_data : r_rf[w_rs];
  assign bus.rt_val_o = (BYPASS && w_cwe && bus.rt == W_COUT) ? bus.cout_data :
                        (BYPASS && w_we && bus.rt == bus.wr_addr) ? bus.write_data : r_rf[bus.rt];
  // copies and architectural writes never coincide since writes need !busy; COUT is last so it wins
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_rf[i] <= '0;
        r_shadow[i] <= '0;
      end
    end else begin
      if (w_copy_en && !w_copy_dir) r_shadow[w_copy_idx] <= r_rf[w_copy_idx];
      if (w_copy_en && w_copy_dir) r_rf[w_copy_idx] <= r_shadow[w_copy_idx];
      if (w_we) r_rf[bus.wr_addr] <= bus.write_data;
      if (w_cwe) r_rf[W_COUT] <= bus.cout_data;
    end
  end
endmodule

// File: tb/tb_banked_reg_file.sv
// tb_banked_reg_file: directed checks of reads, forwarding, save/restore timing and reset abort
module tb_banked_reg_file;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  banked_reg_file_if bif ();
  banked_reg_file dut (.clk(clk), .reset(reset), .bus(bif.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle_in();
    bif.write_enable = 1'b0;
    bif.cout_write_enable = 1'b0;
    bif.ctx_req = 1'b0;
    bif.ctx_cmd = 2'd0;
  endtask
  initial begin
    bif.rs = '0;
    bif.rt = '0;
    bif.wr_addr = '0;
    bif.write_data = '0;
    bif.cout_data = '0;
    idle_in();
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_wr_ready", bif.wr_ready, 1);
    check("rst_shadow_valid", bif.shadow_valid, 0);
    check("rst_busy", bif.ctx_busy, 0);
    check("rst_done", bif.ctx_done, 0);
    check("rst_err", bif.ctx_err, 0);
    for (int i = 0; i < 8; i++) begin
      bif.rt = 3'(i);
      #1;
      check($sformatf("rst_rt%0d", i), bif.rt_val_o, 0);
    end
    bif.write_enable = 1'b1;
    bif.wr_addr = 3'd7;
    bif.write_data = 8'h11;
    bif.cout_write_enable = 1'b1;
    bif.cout_data = 8'h22;
    bif.rt = 3'd7;
    #1;
    check("cout_bypass", bif.rt_val_o, 8'h22);
    tick();
    idle_in();
    #1;
    check("cout_stored", bif.rt_val_o, 8'h22);
    bif.write_enable = 1'b1;
    bif.wr_addr = 3'd3;
    bif.write_data = 8'h33;
    bif.rt = 3'd3;
    bif.rs = 2'd3;
    #1;
    check("gen_bypass_rt", bif.rt_val_o, 8'h33);
    check("gen_bypass_rs", bif.rs_val_o, 8'h33);
    tick();
    for (int i = 0; i < 8; i++) begin
      bif.write_enable = 1'b1;
      bif.wr_addr = 3'(i);
      bif.write_data = 8'(8'h10 + i);
      tick();
    end
    idle_in();
    bif.rs = 2'd1;
    bif.rt = 3'd6;
    #1;
    check("load_rs1", bif.rs_val_o, 8'h11);
    check("load_rt6", bif.rt_val_o, 8'h16);
    bif.ctx_req = 1'b1;
    bif.ctx_cmd = 2'd1;
    tick();
    idle_in();
    for (int c = 0; c < 8; c++) begin
      check($sformatf("save_busy%0d", c), {bif.ctx_busy, bif.wr_ready, bif.ctx_done, bif.ctx_err}, 4'b1000);
      if (c == 2) begin
        bif.write_enable = 1'b1;
        bif.wr_addr = 3'd3;
        bif.write_data = 8'hAA;
        bif.ctx_req = 1'b1;
        bif.ctx_cmd = 2'd1;
      end
      tick();
      idle_in();
    end
    check("save_end_busy", bif.ctx_busy, 0);
    check("save_done", bif.ctx_done, 1);
    check("save_sv", bif.shadow_valid, 1);
    check("save_err", bif.ctx_err, 0);
    bif.rt = 3'd3;
    #1;
    check("save_drop_rf3", bif.rt_val_o, 8'h13);
    for (int i = 0; i < 8; i++) begin
      bif.write_enable = 1'b1;
      bif.wr_addr = 3'(i);
      bif.write_data = 8'hFF;
      tick();
      if (i == 0) check("done_pulse_clear", bif.ctx_done, 0);
    end
    idle_in();
    bif.rt = 3'd5;
    #1;
    check("ovw_rt5", bif.rt_val_o, 8'hFF);
    bif.ctx_req = 1'b1;
    bif.ctx_cmd = 2'd2;
    tick();
    idle_in();
    for (int c = 0; c < 8; c++) begin
      check($sformatf("rest_busy%0d", c), {bif.ctx_busy, bif.ctx_done}, 2'b10);
      tick();
    end
    check("rest_done", {bif.ctx_busy, bif.ctx_done, bif.shadow_valid}, 3'b011);
    for (int i = 0; i < 8; i++) begin
      bif.rt = 3'(i);
      #1;
      check($sformatf("rest_rt%0d", i), bif.rt_val_o, 8'(8'h10 + i));
    end
    bif.ctx_req = 1'b1;
    bif.ctx_cmd = 2'd3;
    tick();
    idle_in();
    check("rsvd_err", {bif.ctx_err, bif.ctx_busy}, 2'b10);
    tick();
    check("rsvd_err_clear", bif.ctx_err, 0);
    bif.ctx_req = 1'b1;
    bif.ctx_cmd = 2'd0;
    tick();
    idle_in();
    check("nop_quiet", {bif.ctx_err, bif.ctx_busy, bif.ctx_done}, 3'b000);
    bif.ctx_req = 1'b1;
    bif.ctx_cmd = 2'd1;
    tick();
    idle_in();
    for (int c = 0; c < 4; c++) tick();
    check("abort_busy_before", bif.ctx_busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("abort_state", {bif.ctx_busy, bif.ctx_done, bif.shadow_valid, bif.wr_ready}, 4'b0001);
    for (int i = 0; i < 8; i++) begin
      bif.rt = 3'(i);
      #1;
      check($sformatf("abort_rt%0d", i), bif.rt_val_o, 0);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("abort_nodone%0d", c), {bif.ctx_busy, bif.ctx_done}, 2'b00);
    end
    bif.ctx_req = 1'b1;
    bif.ctx_cmd = 2'd2;
    tick();
    idle_in();
    check("nosv_err", {bif.ctx_err, bif.ctx_busy}, 2'b10);
    tick();
    check("nosv_err_clear", {bif.ctx_err, bif.ctx_busy}, 2'b00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/banked_reg_file.md
Name: banked_reg_file

Overview:
- Parametrised successor to the CPU's 8-entry register file.
- Keeps two combinational read ports, one general write port and a dedicated COUT register updated by R-type instructions.
- Adds a shadow bank plus a context save/restore sequencer, used for interrupt/context-switch entry and exit.
- Sits between decode (addresses) and the ALU/writeback stage.

Parameters:
- DW, 8, data width of each register
- AW, 3, address width; DEPTH = 2**AW registers
- RS_AW, 2, rs address width (rs reaches the low 2**RS_AW registers only; RS_AW <= AW)
- COUT_IDX, 2**AW-1, index of the COUT register
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads show stored value only

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- rs  input  RS_AW  read port A address, zero-extended to AW
- rt  input  AW  read port B address
- wr_addr  input  AW  general write address
- write_enable  input  1  general write strobe
- write_data  input  DW  general write data
- cout_write_enable  input  1  COUT write strobe
- cout_data  input  DW  COUT write data
- rs_val_o  output  DW  read data A
- rt_val_o  output  DW  read data B
- ctx_req  input  1  context command request, single-cycle qualifier
- ctx_cmd  input  2  00 NOP, 01 SAVE, 10 RESTORE, 11 reserved
- wr_ready  output  1  high when architectural writes are accepted
- ctx_busy  output  1  sequencer active
- ctx_done  output  1  one-cycle pulse on sequence completion
- ctx_err  output  1  one-cycle pulse on a rejected command
- shadow_valid  output  1  shadow bank holds a completed SAVE

Behaviour:
- Reset (synchronous, active-high; also aborts any sequence):
  - All RF and shadow entries become 0; FSM goes to IDLE; index counter 0.
  - ctx_busy=0, ctx_done=0, ctx_err=0, shadow_valid=0, wr_ready=1.
  - Read outputs then reflect the zeroed contents.
- Reads (combinational):
  - rs_val_o = RF[{0,rs}]; rt_val_o = RF[rt].
  - BYPASS=1 and an accepted write to the same index this cycle: output shows the incoming data.
  - A COUT write takes priority over a general write when forwarding COUT_IDX.
- Writes (take effect at the rising edge):
  - Accepted only when wr_ready=1.
  - write_enable writes RF[wr_addr].
  - cout_write_enable writes RF[COUT_IDX].
  - Both active with wr_addr==COUT_IDX: cout_data wins.
  - While wr_ready=0, both strobes are ignored (dropped, not queued); the caller stalls.
- wr_ready = !ctx_busy (combinational).
- FSM states: IDLE, SAVE, RESTORE.
  - IDLE, ctx_req=1, cmd=SAVE: next state SAVE, idx=0.
  - IDLE, ctx_req=1, cmd=RESTORE, shadow_valid=1: next state RESTORE, idx=0.
  - IDLE, ctx_req=1, cmd=RESTORE, shadow_valid=0: stay IDLE; ctx_err pulses next cycle.
  - IDLE, ctx_req=1, cmd=11: stay IDLE; ctx_err pulses next cycle.
  - IDLE, ctx_req=1, cmd=NOP: ignored, no pulse.
  - SAVE: each cycle shadow[idx] <= RF[idx], then idx++.
  - RESTORE: each cycle RF[idx] <= shadow[idx], then idx++.
  - At idx==DEPTH-1: that copy completes, next state is IDLE, idx wraps to 0, ctx_done pulses the following cycle.
  - SAVE completion sets shadow_valid=1; RESTORE leaves it set.
- Latency: request sampled at edge T; ctx_busy=1 for exactly DEPTH cycles; ctx_done=1 and ctx_busy=0 in the cycle after; a write is accepted in that same cycle.
- ctx_req while busy: ignored, no ctx_err.
- Reads during RESTORE return partially restored contents; consumers must not rely on them until ctx_done.
- The general port may address any index including COUT_IDX; only rs is width-restricted.

Decomposition:
- Package reg_file_pkg:
  - ctx_cmd_e enum (CTX_NOP, CTX_SAVE, CTX_RESTORE, CTX_RSVD)
  - ctx_state_e enum (IDLE, SAVE, RESTORE)
  - default DW/AW constants
- Sub-module reg_ctx_seq: FSM, index counter, busy/done/err/shadow_valid flags.
  - Outputs copy_en, copy_dir, copy_idx.
- Top: storage arrays, write arbitration and bypass muxes.

Test Plan:
- Reset then read all 8 via rt -> all 0x00; wr_ready=1, shadow_valid=0.
- Same cycle: write_enable, wr_addr=7, data 0x11; cout_write_enable, cout_data=0x22; rt=7 -> rt_val_o=0x22 that cycle (BYPASS=1); RF[7]=0x22 after the edge.
- Load RF[i]=0x10+i; SAVE -> busy exactly 8 cycles, done one cycle after, shadow_valid=1.
- After that SAVE, overwrite RF with 0xFF; RESTORE -> after done, rt reads 0x10..0x17.
- During SAVE: write_enable to addr 3 with 0xAA -> dropped, RF[3] unchanged; ctx_req SAVE while busy -> no restart, no ctx_err.
- RESTORE with shadow_valid=0 -> ctx_err single pulse, busy stays 0. Separately, reset asserted mid-SAVE at idx=4 -> next cycle IDLE, busy=0, all registers 0, no ctx_done.
